// File: rtl/bus_hold_ctrl_if.sv
// bus_hold_ctrl_if: bus-hold handshake bundle; master drives nbusrq/nwait/T2/mcycle_end/mem_cycle/io_cycle, slave returns hold_clk_*/nbusack/wait_cnt/state
`timescale 1ns/1ps
interface bus_hold_ctrl_if;
  logic       nbusrq;
  logic       nwait;
  logic       T2;
  logic       mcycle_end;
  logic       mem_cycle;
  logic       io_cycle;
  logic       hold_clk_iorq;
  logic       hold_clk_wait;
  logic       hold_clk_busrq;
  logic       nbusack;
  logic [7:0] wait_cnt;
  logic [2:0] state;
  modport master (
    output nbusrq, nwait, T2, mcycle_end, mem_cycle, io_cycle,
    input  hold_clk_iorq, hold_clk_wait, hold_clk_busrq, nbusack, wait_cnt, state
  );
  modport slave (
    input  nbusrq, nwait, T2, mcycle_end, mem_cycle, io_cycle,
    output hold_clk_iorq, hold_clk_wait, hold_clk_busrq, nbusack, wait_cnt, state
  );
endinterface

// File: rtl/bus_hold_ctrl.sv
// bus_hold_ctrl: CPU sequencer hold FSM (IO wait, external wait, bus grant); ports clk, reset (async high), bus (slave: nbusrq/nwait/T2/mcycle_end/mem_cycle/io_cycle in, hold_clk_*/nbusack/wait_cnt/state out)
`timescale 1ns/1ps
module bus_hold_ctrl (
  input logic           clk,
  input logic           reset,
  bus_hold_ctrl_if.slave bus
);
  typedef enum logic [2:0] {RUN = 3'd0, IOW = 3'd1, WAIT = 3'd2, BACK = 3'd3} state_t;
  state_t     r_state;
  state_t     w_next;
  logic       r_iow_done;
  logic       r_nbusrq_s;
  logic       r_nwait_s;
  logic [7:0] r_wait_cnt;
  always_comb begin
    w_next = RUN;
    case (r_state)
      RUN:     w_next = (bus.T2 && bus.io_cycle && !r_iow_done) ? IOW :
                        (bus.T2 && bus.mem_cycle && !r_nwait_s) ? WAIT :
                        (bus.mcycle_end && !r_nbusrq_s)         ? BACK : RUN;
      IOW:     w_next = r_nwait_s ? RUN : WAIT;
      WAIT:    w_next = r_nwait_s ? RUN : WAIT;
      BACK:    w_next = r_nbusrq_s ? RUN : BACK;
      default: w_next = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_iow_done <= 1'b0;
      r_wait_cnt <= 8'd0;
      r_nbusrq_s <= 1'b1;
      r_nwait_s  <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_nbusrq_s <= bus.nbusrq;
      r_nwait_s  <= bus.nwait;
      r_iow_done <= (r_state == IOW) | (r_iow_done & bus.T2);
      if (w_next == WAIT)
        r_wait_cnt <= (r_state != WAIT) ? 8'd1 : r_wait_cnt + {7'd0, r_wait_cnt != 8'hff};
    end
  end
  assign bus.hold_clk_iorq  = r_state == IOW;
  assign bus.hold_clk_wait  = r_state == WAIT;
  assign bus.hold_clk_busrq = r_state == BACK;
  assign bus.nbusack        = r_state != BACK;
  assign bus.wait_cnt       = r_wait_cnt;
  assign bus.state          = r_state;
endmodule

// File: doc/bus_hold_ctrl.md
BUS_HOLD_CTRL -- requirements
Module: bus_hold_ctrl

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  CPU T-clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- nbusrq  in  1  external bus request, active low.
- nwait  in  1  external wait request, active low.
- T2  in  1  sequencer T2 phase strobe.
- mcycle_end  in  1  high during the last T-state of the current M-cycle (nextM or setM1 about to be applied).
- mem_cycle  in  1  current M-cycle is a memory access.
- io_cycle  in  1  current M-cycle is an I/O access.
- hold_clk_iorq  out  1  freeze sequencer for the automatic I/O wait state.
- hold_clk_wait  out  1  freeze sequencer for external wait states.
- hold_clk_busrq  out  1  freeze sequencer while the bus is granted.
- nbusack  out  1  bus acknowledge to pin, active low.
- wait_cnt  out  8  number of clocks spent in the current or most recent WAIT episode.
- state  out  3  current FSM state encoding, for debug.

REQ-002 The block SHALL use one clock, clk, and an asynchronous, active-high reset, reset.

Function
REQ-003 The block SHALL register nbusrq and nwait once into nbusrq_s and nwait_s. All decisions SHALL use the registered copies (1-clock sampling latency).

REQ-004 The FSM states SHALL be: RUN=0, IOW=1, WAIT=2, BACK=3. Codes 4-7 SHALL return to RUN on the next clock.

REQ-005 The outputs SHALL be decoded from the registered state only, with no combinational input-to-output path:
- hold_clk_iorq=1 iff state==IOW.
- hold_clk_wait=1 iff state==WAIT.
- hold_clk_busrq=1 and nbusack=0 iff state==BACK.

REQ-006 RUN transitions SHALL be evaluated in this priority order:
- (a) T2 && io_cycle && !iow_done -> IOW.
- (b) T2 && mem_cycle && !nwait_s -> WAIT.
- (c) mcycle_end && !nbusrq_s -> BACK.
- otherwise stay in RUN.

REQ-007 IOW SHALL last exactly one clock. On leaving it, iow_done SHALL be set to 1, and the next state SHALL be WAIT if nwait_s==0, else RUN.

REQ-008 iow_done SHALL clear on the first clock in which T2==0. This prevents re-entering IOW while the sequencer is still held in T2.

REQ-009 WAIT SHALL persist while nwait_s==0 and SHALL exit to RUN on the clock in which nwait_s==1 is seen.

REQ-010 wait_cnt behaviour:
- It SHALL load 1 on entry to WAIT.
- It SHALL increment by 1 per clock while in WAIT, saturating at 255 with no wrap.
- It SHALL hold its value outside WAIT.

REQ-011 Bus request handling:
- nbusrq SHALL be honoured only at mcycle_end in RUN, never mid-M-cycle.
- An nbusrq pulse that is deasserted before a mcycle_end sample SHALL be ignored.

REQ-012 BACK SHALL persist while nbusrq_s==0 and SHALL return to RUN on the clock in which nbusrq_s==1 is seen. nbusack and hold_clk_busrq SHALL deassert together on that same edge.

REQ-013 If T2 and mcycle_end coincide with wait/IO conditions, the wait or IO hold SHALL win. The bus request SHALL wait for the next mcycle_end.

REQ-014 At most one hold_clk_* output SHALL be high in any clock.

Reset
REQ-015 While reset is high, the block SHALL force:
- state=RUN, iow_done=0, wait_cnt=0.
- nbusrq_s=1, nwait_s=1.
- all hold_clk_*=0, nbusack=1.

REQ-016 Reset asserted mid-WAIT or mid-BACK SHALL take effect immediately (asynchronously), with no completion of the episode.

Verification
REQ-017 The bench SHALL cover at least these directed scenarios:
- IO cycle, T2=1, io_cycle=1, nwait=1 -> hold_clk_iorq=1 for exactly 1 clock, then RUN, and no second IOW while T2 stays high.
- Memory cycle, T2=1, mem_cycle=1, nwait low for 4 clocks -> WAIT entered 1 clock after the sample, hold_clk_wait high for 4 clocks, wait_cnt=4 afterwards.
- IO cycle with nwait held low -> IOW for 1 clock, then WAIT until nwait is released; hold_clk_iorq and hold_clk_wait never both high.
- nbusrq low asserted mid-M-cycle -> nbusack stays 1 until mcycle_end, then nbusack=0 and hold_clk_busrq=1. Releasing nbusrq -> both return to idle 1 clock after the sampled release.
- nwait held low for 300 clocks -> wait_cnt saturates at 255.
- reset pulsed while in BACK -> nbusack=1, hold_clk_busrq=0, state=0 immediately, with no wait for a clk edge.
